// File: rtl/cornet_bus_pkg.sv
// Shared definitions for the memory bus arbiter:
// FSM state encodings and default bus widths.
package cornet_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side and memory-side signals of the shared memory port.
// slave = arbiter view, master = masters plus memory view.
interface mem_bus_arbiter_if
    import cornet_bus_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_lock;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_ack;
    logic            m_err;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_grant;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_req;
    logic            mem_wr_en;
    logic [DW-1:0]   mem_wr_data;
    logic [DW-1:0]   mem_rd_data;
    logic            mem_ack;

    modport slave (
        input  m_req, m_we, m_lock, m_addr, m_wdata,
        input  mem_rd_data, mem_ack,
        output m_ack, m_err, m_rdata, m_grant,
        output mem_addr, mem_rd_req, mem_wr_en, mem_wr_data
    );

    modport master (
        output m_req, m_we, m_lock, m_addr, m_wdata,
        output mem_rd_data, mem_ack,
        input  m_ack, m_err, m_rdata, m_grant,
        input  mem_addr, mem_rd_req, mem_wr_en, mem_wr_data
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin winner select with lock override.
// Scans upward from ptr+1, wrapping at N.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          lock_valid,
    input  logic [IW-1:0] lock_idx,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int w_j;

    // Descending offset loop: the nearest requester after ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_j   = 0;
        if (lock_valid) begin
            valid = req[lock_idx];
            idx   = lock_idx;
        end else begin
            for (int k = N; k >= 1; k--) begin
                w_j = (int'(ptr) + k) % N;
                if (req[w_j[IW-1:0]]) begin
                    valid = 1'b1;
                    idx   = w_j[IW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between N masters,
// with per-master bus lock and an ack timeout.
module mem_bus_arbiter
    import cornet_bus_pkg::*;
#(
    parameter int N       = 3,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    arb_state_t    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_own;
    logic [IW-1:0] r_lock_idx;
    logic          r_lock_v;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_ack;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_addr;
    logic          r_rd;
    logic          r_wr;

    logic          w_valid;
    logic [IW-1:0] w_idx;
    logic [N-1:0]  w_win_oh;
    logic [N-1:0]  w_own_oh;
    logic          w_tmo;
    logic          w_unlock;

    rr_picker #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req        (bus.m_req),
        .ptr        (r_ptr),
        .lock_valid (r_lock_v),
        .lock_idx   (r_lock_idx),
        .valid      (w_valid),
        .idx        (w_idx)
    );

    assign w_win_oh = N'(1) << w_idx;
    assign w_own_oh = N'(1) << r_own;
    assign w_tmo    = (TIMEOUT != 0) && (r_cnt == CW'(TLAST));
    assign w_unlock = r_lock_v && !bus.m_lock[r_lock_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_own      <= '0;
            r_lock_idx <= '0;
            r_lock_v   <= 1'b0;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_unlock) begin
                        r_lock_v <= 1'b0;
                        r_grant  <= '0;
                    end
                    if (w_valid) begin
                        r_grant <= w_win_oh;
                        r_own   <= w_idx;
                        r_addr  <= bus.m_addr[w_idx*AW +: AW];
                        r_wdata <= bus.m_wdata[w_idx*DW +: DW];
                        r_we    <= bus.m_we[w_idx];
                        r_rd    <= !bus.m_we[w_idx];
                        r_wr    <= bus.m_we[w_idx];
                        r_cnt   <= '0;
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus.mem_ack || w_tmo) begin
                        r_rd       <= 1'b0;
                        r_wr       <= 1'b0;
                        r_ack      <= w_own_oh;
                        r_err      <= !bus.mem_ack;
                        r_ptr      <= r_own;
                        r_lock_v   <= bus.m_lock[r_own];
                        r_lock_idx <= r_own;
                        r_state    <= ARB_DONE;
                        if (!bus.mem_ack) begin
                            r_rdata <= '0;
                        end else if (!r_we) begin
                            r_rdata <= bus.mem_rd_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ARB_DONE: begin
                    r_err <= 1'b0;
                    if (!r_lock_v) begin
                        r_grant <= '0;
                    end
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.m_ack       = r_ack;
    assign bus.m_err       = r_err;
    assign bus.m_rdata     = r_rdata;
    assign bus.m_grant     = r_grant;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_rd_req  = r_rd;
    assign bus.mem_wr_en   = r_wr;
    assign bus.mem_wr_data = r_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed reset/lock/write cases, then
// random masters and memory against a transaction-timeline model.
module tb_mem_bus_arbiter;

    localparam int N   = 3;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem [0:65535];

    mem_bus_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    mem_bus_arbiter #(
        .N       (N),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.m_req       = '0;
        bus.m_we        = '0;
        bus.m_lock      = '0;
        bus.m_addr      = '0;
        bus.m_wdata     = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = '0;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Next owner from the arbitration rules: lock first, else scan after lst.
    function automatic int pick(logic [N-1:0] req, int lst, bit lv, int l);
        if (lv) return req[l] ? l : -1;
        for (int k = 1; k <= N; k++) begin
            if (req[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    // Model state: edge numbers of the current transaction.
    int          n, g_e, c_e, ack_e, done_e, lat, win, w, last, lk;
    bit          act, lk_v, t_we, t_err;
    logic [15:0] t_addr;
    logic [7:0]  t_wd;
    logic [N-1:0] e_grant, e_ack;
    bit          e_err, e_rd, e_wr;
    logic [7:0]  e_rdata;

    task automatic new_req(input int i);
        bus.m_req[i]           = 1'b1;
        bus.m_we[i]            = 1'($urandom_range(0, 1));
        bus.m_addr[i*AW +: AW] = 16'h2000 | 16'($urandom_range(0, 15));
        bus.m_wdata[i*DW +: DW] = 8'($urandom);
        bus.m_lock[i]          = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h3C;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h04;

        // power-up reset state
        clr_in();
        tick();
        tick();
        check("rst_grant", bus.m_grant, 0);
        check("rst_ack", bus.m_ack, 0);
        check("rst_err", bus.m_err, 0);
        check("rst_rd", bus.mem_rd_req, 0);
        check("rst_wr", bus.mem_wr_en, 0);
        check("rst_rdata", bus.m_rdata, 0);
        check("rst_addr", bus.mem_addr, 0);
        reset = 1'b0;

        // reset in the middle of a read wait
        bus.m_req[0]       = 1'b1;
        bus.m_addr[15:0]   = 16'h0010;
        tick();
        check("t1_rd", bus.mem_rd_req, 1);
        check("t1_grant", bus.m_grant, 3'b001);
        #3 reset = 1'b1;
        #1;
        check("t1_async_rd", bus.mem_rd_req, 0);
        check("t1_async_grant", bus.m_grant, 0);
        check("t1_async_addr", bus.mem_addr, 0);
        bus.mem_ack = 1'b1;
        tick();
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        check("t1_noack", bus.m_ack, 0);
        tick();
        check("t1_serve_rd", bus.mem_rd_req, 1);
        check("t1_serve_ack0", bus.m_ack, 0);
        bus.mem_ack     = 1'b1;
        bus.mem_rd_data = 8'h77;
        tick();
        check("t1_ack", bus.m_ack, 3'b001);
        check("t1_rdata", bus.m_rdata, 8'h77);
        bus.mem_ack  = 1'b0;
        bus.m_req    = '0;
        tick();
        check("t1_idle_ack", bus.m_ack, 0);
        check("t1_idle_grant", bus.m_grant, 0);

        // locked word read by master 0 while master 1 waits
        do_reset();
        bus.m_lock[0]         = 1'b1;
        bus.m_req[0]          = 1'b1;
        bus.m_addr[15:0]      = 16'hFFFC;
        bus.m_addr[31:16]     = 16'h0100;
        tick();
        check("t3_grant0", bus.m_grant, 3'b001);
        check("t3_addr0", bus.mem_addr, 16'hFFFC);
        bus.m_req[1]    = 1'b1;
        bus.mem_ack     = 1'b1;
        bus.mem_rd_data = mem[16'hFFFC];
        tick();
        check("t3_ack0", bus.m_ack, 3'b001);
        check("t3_lo", bus.m_rdata, 8'h00);
        bus.mem_ack      = 1'b0;
        bus.m_addr[15:0] = 16'hFFFD;
        tick();
        check("t3_hold", bus.m_grant, 3'b001);
        tick();
        check("t3_grant1", bus.m_grant, 3'b001);
        check("t3_addr1", bus.mem_addr, 16'hFFFD);
        bus.mem_ack     = 1'b1;
        bus.mem_rd_data = mem[16'hFFFD];
        tick();
        check("t3_hi", bus.m_rdata, 8'h04);
        bus.mem_ack  = 1'b0;
        bus.m_req[0] = 1'b0;
        tick();
        tick();
        check("t3_block_grant", bus.m_grant, 3'b001);
        check("t3_block_rd", bus.mem_rd_req, 0);
        bus.m_lock[0] = 1'b0;
        tick();
        check("t3_rel_grant", bus.m_grant, 0);
        check("t3_rel_rd", bus.mem_rd_req, 0);
        tick();
        check("t3_m1_grant", bus.m_grant, 3'b010);
        check("t3_m1_addr", bus.mem_addr, 16'h0100);
        bus.mem_ack = 1'b1;
        tick();
        check("t3_m1_ack", bus.m_ack, 3'b010);
        bus.mem_ack = 1'b0;
        bus.m_req   = '0;
        tick();

        // byte write from master 2
        do_reset();
        bus.m_req[2]      = 1'b1;
        bus.m_we[2]       = 1'b1;
        bus.m_addr[47:32] = 16'h1000;
        bus.m_wdata[23:16] = 8'hAA;
        tick();
        check("t4_wr", bus.mem_wr_en, 1);
        check("t4_rd", bus.mem_rd_req, 0);
        check("t4_wdata", bus.mem_wr_data, 8'hAA);
        check("t4_addr", bus.mem_addr, 16'h1000);
        check("t4_grant", bus.m_grant, 3'b100);
        tick();
        check("t4_rd_wait", bus.mem_rd_req, 0);
        bus.mem_ack = 1'b1;
        tick();
        check("t4_ack", bus.m_ack, 3'b100);
        check("t4_wr_off", bus.mem_wr_en, 0);
        check("t4_rd_off", bus.mem_rd_req, 0);
        bus.mem_ack = 1'b0;
        bus.m_req   = '0;
        tick();

        // random masters, random memory latency 1..5 (5 = timeout)
        do_reset();
        n = 0; last = 0; lk_v = 0; lk = 0; act = 0;
        done_e = -10; ack_e = -1; g_e = 0; c_e = 0; w = 0;
        e_grant = '0; e_ack = '0; e_err = 0; e_rd = 0; e_wr = 0;
        e_rdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.m_req[i]) begin
                    if (e_ack[i]) begin
                        if ($urandom_range(0, 1) == 1) new_req(i);
                        else bus.m_req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i);
                end else if ($urandom_range(0, 1) == 1) begin
                    bus.m_lock[i] = 1'b0;
                end
            end
            bus.mem_ack = (n + 1 == ack_e) ||
                          (!act && $urandom_range(0, 9) == 0);
            bus.mem_rd_data = (act && n + 1 == ack_e) ?
                              mem[t_addr] : 8'($urandom);

            @(posedge clk);
            n++;
            if (act && n == c_e) begin
                act     = 0;
                done_e  = n;
                e_ack   = N'(1) << w;
                e_err   = t_err;
                e_rd    = 0;
                e_wr    = 0;
                if (t_err) e_rdata = '0;
                else if (!t_we) e_rdata = mem[t_addr];
                else mem[t_addr] = t_wd;
                last = w;
                lk_v = bus.m_lock[w];
                lk   = w;
            end else if (!act && n == done_e + 1) begin
                e_ack   = '0;
                e_err   = 0;
                e_grant = lk_v ? N'(1) << lk : '0;
            end else if (!act) begin
                win = pick(bus.m_req, last, lk_v, lk);
                if (lk_v && !bus.m_lock[lk]) begin
                    lk_v    = 0;
                    e_grant = '0;
                end
                if (win >= 0) begin
                    act     = 1;
                    w       = win;
                    g_e     = n;
                    t_we    = bus.m_we[w];
                    t_addr  = bus.m_addr[w*AW +: AW];
                    t_wd    = bus.m_wdata[w*DW +: DW];
                    e_grant = N'(1) << w;
                    e_rd    = !t_we;
                    e_wr    = t_we;
                    lat     = $urandom_range(1, 5);
                    ack_e   = g_e + lat;
                    c_e     = g_e + ((lat <= TMO) ? lat : TMO);
                    t_err   = (lat > TMO);
                end
            end
            #1;
            check("r_grant", bus.m_grant, e_grant);
            check("r_ack", bus.m_ack, e_ack);
            check("r_err", bus.m_err, e_err);
            check("r_rd", bus.mem_rd_req, e_rd);
            check("r_wr", bus.mem_wr_en, e_wr);
            check("r_rdata", bus.m_rdata, e_rdata);
            if (act) begin
                check("r_addr", bus.mem_addr, t_addr);
                if (t_we) check("r_wdata", bus.mem_wr_data, t_wd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
